// File: rtl/four_bit_comparator_pkg.sv
// Shared width, flag bundle and cascade-resolution helper for the 4-bit
// magnitude comparator.
package four_bit_comparator_pkg;

    localparam int W = 4;

    typedef struct packed {
        logic g;
        logic e;
        logic l;
    } cmp_flags_t;

    // Neutral cascade value: what an LSB stage is fed and what reset produces.
    localparam cmp_flags_t CMP_NEUTRAL = '{g: 1'b0, e: 1'b1, l: 1'b0};

    // A decided bit position wins outright; otherwise the cascade passes
    // through verbatim, so an illegal upstream pattern stays visible.
    function automatic cmp_flags_t cmp_resolve(
        input logic       any_gt,
        input logic       any_lt,
        input logic       all_eq,
        input cmp_flags_t cascade
    );
        cmp_flags_t res;
        if (all_eq) begin
            res = cascade;
        end else begin
            res = '{g: any_gt, e: 1'b0, l: any_lt};
        end
        return res;
    endfunction

endpackage

// File: rtl/four_bit_comparator_if.sv
// Signal bundle for one comparator stage: operands, cascade in, flags out.
interface four_bit_comparator_if;
    import four_bit_comparator_pkg::*;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         g_in;
    logic         e_in;
    logic         l_in;
    logic         g_out;
    logic         e_out;
    logic         l_out;

    modport master (
        output a, b, g_in, e_in, l_in,
        input  g_out, e_out, l_out
    );

    modport slave (
        input  a, b, g_in, e_in, l_in,
        output g_out, e_out, l_out
    );

endinterface

// File: rtl/comparator_bit_slice.sv
// One bit position of the magnitude compare; it only decides when every
// higher bit was equal.
module comparator_bit_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic eq_above_i,
    output logic gt_o,
    output logic lt_o,
    output logic eq_chain_o
);

    assign gt_o       = eq_above_i &  a_i & ~b_i;
    assign lt_o       = eq_above_i & ~a_i &  b_i;
    assign eq_chain_o = eq_above_i & ~(a_i ^ b_i);

endmodule

// File: rtl/four_bit_comparator.sv
// Cascadable 4-bit unsigned magnitude comparator (7485-style) with one
// cycle of output latency and a synchronous reset to the neutral cascade.
module four_bit_comparator
    import four_bit_comparator_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         g_in,
    input  logic         e_in,
    input  logic         l_in,
    output logic         g_out,
    output logic         e_out,
    output logic         l_out
);

    // eq_chain[i+1] is high when bits W-1..i+1 all match; the top seed is 1.
    logic [W:0]   eq_chain;
    logic [W-1:0] gt_bits;
    logic [W-1:0] lt_bits;
    cmp_flags_t   cascade;
    cmp_flags_t   flags_d;
    cmp_flags_t   flags_q;

    assign eq_chain[W] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_slice
            comparator_bit_slice u_slice (
                .a_i        (a[gi]),
                .b_i        (b[gi]),
                .eq_above_i (eq_chain[gi+1]),
                .gt_o       (gt_bits[gi]),
                .lt_o       (lt_bits[gi]),
                .eq_chain_o (eq_chain[gi])
            );
        end
    endgenerate

    assign cascade = '{g: g_in, e: e_in, l: l_in};

    always_comb begin
        flags_d = cmp_resolve(|gt_bits, |lt_bits, eq_chain[0], cascade);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= CMP_NEUTRAL;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign g_out = flags_q.g;
    assign e_out = flags_q.e;
    assign l_out = flags_q.l;

endmodule

// File: tb/tb_four_bit_comparator.sv
// Self-checking bench: reset, exhaustive sweep with a mid-stream reset,
// directed cascade vectors and a two-stage 8-bit chain.
module tb_four_bit_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hi_a;
    logic [3:0] hi_b;
    logic       hi_g;
    logic       hi_e;
    logic       hi_l;

    always #5 clk = ~clk;

    four_bit_comparator_if bus ();

    four_bit_comparator dut (
        .clk   (clk),
        .rst   (rst),
        .a     (bus.a),
        .b     (bus.b),
        .g_in  (bus.g_in),
        .e_in  (bus.e_in),
        .l_in  (bus.l_in),
        .g_out (bus.g_out),
        .e_out (bus.e_out),
        .l_out (bus.l_out)
    );

    // High-order stage of the 8-bit chain, fed by the main instance.
    four_bit_comparator dut_hi (
        .clk   (clk),
        .rst   (rst),
        .a     (hi_a),
        .b     (hi_b),
        .g_in  (bus.g_out),
        .e_in  (bus.e_out),
        .l_in  (bus.l_out),
        .g_out (hi_g),
        .e_out (hi_e),
        .l_out (hi_l)
    );

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] casc;
        logic [2:0] exp;
    } vec_t;

    vec_t       vecs [10];
    logic [2:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
            $display("ok   %s out=%b", name, act);
        end else begin
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] av, input logic [3:0] bv,
                         input logic [2:0] casc, input logic [2:0] req);
        rst      = r;
        bus.a    = av;
        bus.b    = bv;
        bus.g_in = casc[2];
        bus.e_in = casc[1];
        bus.l_in = casc[0];
        exp_q.push_back(req);
    endtask

    // Advance one edge, then compare the main stage against the oldest expectation.
    task automatic sample(input string name, input logic chk_onehot);
        logic [2:0] req;
        logic [2:0] act;
        @(posedge clk);
        #1;
        act = {bus.g_out, bus.e_out, bus.l_out};
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s actual=empty_scoreboard required=entry", name);
        end else begin
            req = exp_q.pop_front();
            check3(name, act, req);
        end
        if (chk_onehot) begin
            n_checks++;
            if ($onehot(act)) n_pass++;
            else $display("FAIL %s_onehot actual=%b required=one_hot", name, act);
        end
    endtask

    initial begin
        logic [2:0] req;
        hi_a = 4'd0;
        hi_b = 4'd0;

        vecs[0] = '{"pass_100", 4'd9,  4'd9,  3'b100, 3'b100};
        vecs[1] = '{"pass_001", 4'd9,  4'd9,  3'b001, 3'b001};
        vecs[2] = '{"pass_000", 4'd9,  4'd9,  3'b000, 3'b000};
        vecs[3] = '{"pass_111", 4'd9,  4'd9,  3'b111, 3'b111};
        vecs[4] = '{"ign_gt",   4'd8,  4'd7,  3'b001, 3'b100};
        vecs[5] = '{"ign_lt",   4'd7,  4'd8,  3'b100, 3'b001};
        vecs[6] = '{"b_0_15",   4'd0,  4'd15, 3'b010, 3'b001};
        vecs[7] = '{"b_15_0",   4'd15, 4'd0,  3'b010, 3'b100};
        vecs[8] = '{"b_0_0",    4'd0,  4'd0,  3'b010, 3'b010};
        vecs[9] = '{"b_15_15",  4'd15, 4'd15, 3'b010, 3'b010};

        // Reset held for two edges, then released with a=5 > b=3.
        drive(1'b1, 4'd5, 4'd3, 3'b010, 3'b010);
        sample("reset_0", 1'b0);
        drive(1'b1, 4'd5, 4'd3, 3'b010, 3'b010);
        sample("reset_1", 1'b0);
        drive(1'b0, 4'd5, 4'd3, 3'b010, 3'b100);
        sample("reset_release", 1'b0);

        // Exhaustive sweep with one reset cycle injected at a=12, b=4.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                if (ai == 12 && bi == 4) begin
                    drive(1'b1, 4'(ai), 4'(bi), 3'b010, 3'b010);
                    sample("sweep_rst", 1'b1);
                end
                req = {ai > bi, ai == bi, ai < bi};
                drive(1'b0, 4'(ai), 4'(bi), 3'b010, req);
                sample($sformatf("sweep_a%0d_b%0d", ai, bi), 1'b1);
            end
        end

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, vecs[i].a, vecs[i].b, vecs[i].casc, vecs[i].exp);
            sample(vecs[i].name, 1'b0);
        end

        // 8-bit chain 0x34 vs 0x35: low nibbles decide, high nibbles equal.
        hi_a = 4'h3;
        hi_b = 4'h3;
        drive(1'b0, 4'h4, 4'h5, 3'b010, 3'b001);
        sample("chain_lo", 1'b0);
        drive(1'b0, 4'h4, 4'h5, 3'b010, 3'b001);
        sample("chain_lo_hold", 1'b0);
        check3("chain_hi", {hi_g, hi_e, hi_l}, 3'b001);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
